// File: rtl/alu_share_arbiter.sv
// Shared ALU with a round-robin arbiter over NUM_REQ valid/ready requesters.
// One operation in flight: IDLE (arbitrate) -> EXEC (evaluate) -> RESP (hold result).

// Combinational ALU; o_legal flags whether i_func is one of the defined codes.
module alu_share_arbiter_alu #(
  parameter int unsigned WORD_SIZE = 32,
  parameter int unsigned FUNC_BITS = 5
) (
  input  logic [WORD_SIZE-1:0] i_in1,
  input  logic [WORD_SIZE-1:0] i_in2,
  input  logic [FUNC_BITS-1:0] i_func,
  output logic [WORD_SIZE-1:0] o_out,
  output logic                 o_legal
);
  localparam int unsigned HALF = WORD_SIZE / 2;

  localparam logic [FUNC_BITS-1:0] FN_ADD  = FUNC_BITS'(5'b00000);
  localparam logic [FUNC_BITS-1:0] FN_SUB  = FUNC_BITS'(5'b00001);
  localparam logic [FUNC_BITS-1:0] FN_AND  = FUNC_BITS'(5'b00100);
  localparam logic [FUNC_BITS-1:0] FN_OR   = FUNC_BITS'(5'b00101);
  localparam logic [FUNC_BITS-1:0] FN_XOR  = FUNC_BITS'(5'b00110);
  localparam logic [FUNC_BITS-1:0] FN_MVHI = FUNC_BITS'(5'b01011);
  localparam logic [FUNC_BITS-1:0] FN_NAND = FUNC_BITS'(5'b01100);
  localparam logic [FUNC_BITS-1:0] FN_NOR  = FUNC_BITS'(5'b01101);
  localparam logic [FUNC_BITS-1:0] FN_XNOR = FUNC_BITS'(5'b01110);
  localparam logic [FUNC_BITS-1:0] FN_F    = FUNC_BITS'(5'b10000);
  localparam logic [FUNC_BITS-1:0] FN_EQ   = FUNC_BITS'(5'b10001);
  localparam logic [FUNC_BITS-1:0] FN_LT   = FUNC_BITS'(5'b10010);
  localparam logic [FUNC_BITS-1:0] FN_LTE  = FUNC_BITS'(5'b10011);
  localparam logic [FUNC_BITS-1:0] FN_T    = FUNC_BITS'(5'b11000);
  localparam logic [FUNC_BITS-1:0] FN_NE   = FUNC_BITS'(5'b11001);
  localparam logic [FUNC_BITS-1:0] FN_GTE  = FUNC_BITS'(5'b11010);
  localparam logic [FUNC_BITS-1:0] FN_GT   = FUNC_BITS'(5'b11011);

  // Function decode; undefined codes drive zero rather than floating
  always_comb begin
    o_out   = '0;
    o_legal = 1'b1;
    case (i_func)
      FN_ADD:  o_out = i_in1 + i_in2;
      FN_SUB:  o_out = i_in1 - i_in2;
      FN_AND:  o_out = i_in1 & i_in2;
      FN_OR:   o_out = i_in1 | i_in2;
      FN_XOR:  o_out = i_in1 ^ i_in2;
      FN_NAND: o_out = ~(i_in1 & i_in2);
      FN_NOR:  o_out = ~(i_in1 | i_in2);
      FN_XNOR: o_out = ~(i_in1 ^ i_in2);
      FN_MVHI: o_out = i_in1 << HALF;
      FN_F:    o_out = '0;
      FN_EQ:   o_out = WORD_SIZE'(i_in1 == i_in2);
      FN_LT:   o_out = WORD_SIZE'(i_in1 < i_in2);
      FN_LTE:  o_out = WORD_SIZE'(i_in1 <= i_in2);
      FN_T:    o_out = WORD_SIZE'(1);
      FN_NE:   o_out = WORD_SIZE'(i_in1 != i_in2);
      FN_GTE:  o_out = WORD_SIZE'(i_in1 >= i_in2);
      FN_GT:   o_out = WORD_SIZE'(i_in1 > i_in2);
      default: o_legal = 1'b0;
    endcase
  end
endmodule

module alu_share_arbiter #(
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned WORD_SIZE = 32,
  parameter int unsigned FUNC_BITS = 5
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NUM_REQ-1:0]             req_valid,
  output logic [NUM_REQ-1:0]             req_ready,
  input  logic [NUM_REQ*WORD_SIZE-1:0]   req_in1,
  input  logic [NUM_REQ*WORD_SIZE-1:0]   req_in2,
  input  logic [NUM_REQ*FUNC_BITS-1:0]   req_func,
  output logic [NUM_REQ-1:0]             rsp_valid,
  input  logic [NUM_REQ-1:0]             rsp_ready,
  output logic [WORD_SIZE-1:0]           rsp_data,
  output logic                           rsp_err,
  output logic                           busy
);
  localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  logic [1:0]           r_state;
  logic [1:0]           w_state_nxt;
  logic [IDX_W-1:0]     r_rr_ptr;
  logic [IDX_W-1:0]     r_owner;
  logic [WORD_SIZE-1:0] r_in1;
  logic [WORD_SIZE-1:0] r_in2;
  logic [FUNC_BITS-1:0] r_func;
  logic [WORD_SIZE-1:0] r_res;
  logic                 r_err;

  logic [WORD_SIZE-1:0] w_in1  [NUM_REQ];
  logic [WORD_SIZE-1:0] w_in2  [NUM_REQ];
  logic [FUNC_BITS-1:0] w_func [NUM_REQ];
  logic                 w_found;
  logic [IDX_W-1:0]     w_grant_idx;
  int unsigned          w_cand;
  logic                 w_accept;
  logic [IDX_W-1:0]     w_ptr_nxt;
  logic [WORD_SIZE-1:0] w_alu_out;
  logic                 w_alu_legal;

  // Unpack the flattened request buses into per-requester arrays
  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign w_in1[g]  = req_in1[g*WORD_SIZE +: WORD_SIZE];
    assign w_in2[g]  = req_in2[g*WORD_SIZE +: WORD_SIZE];
    assign w_func[g] = req_func[g*FUNC_BITS +: FUNC_BITS];
  end

  // Round-robin search: first valid requester at or after r_rr_ptr, with wrap
  always_comb begin
    w_found     = 1'b0;
    w_grant_idx = '0;
    w_cand      = 0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      w_cand = 32'(r_rr_ptr) + k;
      if (w_cand >= NUM_REQ) w_cand = w_cand - NUM_REQ;
      if (!w_found && req_valid[IDX_W'(w_cand)]) begin
        w_found     = 1'b1;
        w_grant_idx = IDX_W'(w_cand);
      end
    end
  end

  // Grant only from IDLE and never during reset; depends on state, not rsp_ready
  always_comb begin
    w_accept  = (r_state == S_IDLE) && !reset && w_found;
    req_ready = w_accept ? (NUM_REQ'(1) << w_grant_idx) : '0;
    w_ptr_nxt = (w_grant_idx == IDX_W'(NUM_REQ - 1)) ? '0 : w_grant_idx + IDX_W'(1);
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_found) w_state_nxt = S_EXEC;
      S_EXEC:  w_state_nxt = S_RESP;
      S_RESP:  if (rsp_ready[r_owner]) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Operand/owner capture on grant, result capture at the end of EXEC
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rr_ptr <= '0;
      r_owner  <= '0;
      r_in1    <= '0;
      r_in2    <= '0;
      r_func   <= '0;
      r_res    <= '0;
      r_err    <= 1'b0;
    end else begin
      if (w_accept) begin
        r_in1    <= w_in1[w_grant_idx];
        r_in2    <= w_in2[w_grant_idx];
        r_func   <= w_func[w_grant_idx];
        r_owner  <= w_grant_idx;
        r_rr_ptr <= w_ptr_nxt;
      end
      if (r_state == S_EXEC) begin
        r_res <= w_alu_legal ? w_alu_out : '0;
        r_err <= !w_alu_legal;
      end
    end
  end

  alu_share_arbiter_alu #(
    .WORD_SIZE (WORD_SIZE),
    .FUNC_BITS (FUNC_BITS)
  ) u_alu (
    .i_in1   (r_in1),
    .i_in2   (r_in2),
    .i_func  (r_func),
    .o_out   (w_alu_out),
    .o_legal (w_alu_legal)
  );

  // Response outputs decoded straight from registers
  always_comb begin
    rsp_valid = (r_state == S_RESP) ? (NUM_REQ'(1) << r_owner) : '0;
    rsp_data  = r_res;
    rsp_err   = r_err;
    busy      = (r_state != S_IDLE);
  end
endmodule

// File: doc/alu_share_arbiter.md
Name: alu_share_arbiter

Overview:
- Shares one Alu instance between NUM_REQ requesters (fetch-stage branch compare, execute stage, address-gen helper, debug port).
- Each requester uses a valid/ready request channel and a valid/ready response channel.
- A round-robin arbiter picks one request and latches its operands. The ALU result is registered and held until the owning requester accepts it.
- Only one operation is in flight at a time.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- WORD_SIZE, 32, operand/result width; passed to the Alu.
- FUNC_BITS, 5, ALU function code width; passed to the Alu.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- req_valid  input  NUM_REQ  per-requester request valid.
- req_ready  output  NUM_REQ  per-requester request accept; one-hot or zero.
- req_in1  input  NUM_REQ*WORD_SIZE  flattened operand 1; requester i at bits [i*WORD_SIZE +: WORD_SIZE].
- req_in2  input  NUM_REQ*WORD_SIZE  flattened operand 2; same packing as req_in1.
- req_func  input  NUM_REQ*FUNC_BITS  flattened ALU function code; same packing.
- rsp_valid  output  NUM_REQ  per-requester response valid; one-hot or zero.
- rsp_ready  input  NUM_REQ  per-requester response accept.
- rsp_data  output  WORD_SIZE  shared result bus; meaningful only where rsp_valid is set.
- rsp_err  output  1  qualifies rsp_data: func was not a legal ALU code.
- busy  output  1  high whenever state != IDLE.

Behaviour:
- FSM states:
  - IDLE: arbitrate among requesters.
  - EXEC: the Alu evaluates latched operands combinationally; the result is captured into res_q at the end of the cycle.
  - RESP: hold the response for the owner.
- Transitions:
  - IDLE->EXEC when any req_valid is set.
  - EXEC->RESP unconditionally.
  - RESP->IDLE when rsp_ready[owner] is high.
  - All other cases hold state.
- Arbitration (combinational, IDLE only):
  - Grant the first set req_valid at or after rr_ptr, scanning upward with wrap from NUM_REQ-1 to 0.
  - req_ready[grant] = 1 in that IDLE cycle; all req_ready = 0 in other states.
- Handshake capture: on req_valid&req_ready, latch in1/in2/func into op registers and owner index into owner_q; set rr_ptr = (grant+1) mod NUM_REQ.
- Latency: request accepted at cycle T; rsp_valid[owner] high from T+2. Minimum issue interval is 3 cycles.
- rsp_valid[owner_q] = 1 only in RESP. rsp_data = res_q and rsp_err = err_q, both stable throughout RESP.
- Backpressure: RESP holds indefinitely while rsp_ready[owner] = 0. Requests stay pending; req_valid must remain high until accepted.
- rsp_ready on non-owner bits is ignored.
- Illegal func check:
  - Legal codes are the 17 defined ALU codes (ADD, SUB, AND, OR, XOR, NAND, NOR, XNOR, MVHI, F, EQ, LT, LTE, T, NE, GTE, GT) from the team's ALU header.
  - Any other code gives res_q = 0 and err_q = 1. The Alu's high-impedance output must never reach rsp_data.
- Arithmetic is the Alu's: unsigned compares, modulo-2^WORD_SIZE add/sub, compare results 0 or 1 zero-extended.
- Reset (synchronous, any state, including mid-EXEC/RESP):
  - state = IDLE, rr_ptr = 0, owner_q = 0, op/res/err registers = 0.
  - req_ready = 0 during the reset cycle; rsp_valid = 0, rsp_data = 0, rsp_err = 0, busy = 0.
  - An in-flight operation is dropped with no response.
- Simultaneous events:
  - A request arriving in the same cycle a response is accepted is not granted until the following IDLE cycle.
  - Deassertion of req_valid while not ready is tolerated.
- No combinational path from rsp_ready to req_ready.

Test Plan:
- Single ADD: req 0, in1=5, in2=7, func=ADD, accepted at T -> rsp_valid[0] at T+2, rsp_data=12, rsp_err=0; busy high T+1..release.
- Contention and round-robin: req_valid=4'b0101 held, rr_ptr=0 -> grants 0 then 2 then 0. Then add req 3 with rr_ptr=3 -> 3 is granted before 0 (wrap).
- Backpressure: SUB in1=3, in2=5 on req 1 with rsp_ready[1]=0 for 10 cycles -> rsp_data=32'hFFFFFFFE held stable, req_ready all 0. rsp_ready[2]=1 meanwhile has no effect.
- Compare and MVHI: LT 2,9 -> 1; GTE 2,9 -> 0; MVHI in1=16'h1234 -> 32'h12340000.
- Illegal func: code not in the legal set (e.g. 5'h1F if unassigned) -> rsp_data=0, rsp_err=1, FSM returns to IDLE normally.
- Reset mid-operation: assert reset in EXEC and separately in RESP -> next cycle all outputs 0, state IDLE, rr_ptr=0, no rsp_valid. A fresh request afterward completes correctly.
